// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared definitions for the PS/2 keyboard controller: sequencer states,
// byte classes and the scan-code constants the decoder cares about.
package ps2_kbd_ctrl_pkg;

    // Pop sequencer: wait for a byte, acknowledge it, then one settle cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Classification of a received byte.
    typedef enum logic [2:0] {
        CLS_BRK   = 3'd0,
        CLS_EXT   = 3'd1,
        CLS_SHIFT = 3'd2,
        CLS_CTRL  = 3'd3,
        CLS_OTHER = 3'd4
    } code_class_e;

    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;

    // E0 12 is the fake-shift that some keyboards inject around extended keys.
    function automatic logic is_fake_shift(input logic ext_pend, input logic [7:0] code);
        return ext_pend && (code == SC_LSHIFT);
    endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_code_class.sv
// Combinational classifier mapping a scan-code byte to its decode class.
module ps2_code_class
    import ps2_kbd_ctrl_pkg::*;
(
    input  logic [7:0]  code_i,
    output code_class_e class_o
);

    // Pure lookup; anything not a prefix or modifier is an ordinary key.
    always_comb begin
        class_o = CLS_OTHER;
        case (code_i)
            SC_BRK:               class_o = CLS_BRK;
            SC_EXT:               class_o = CLS_EXT;
            SC_LSHIFT, SC_RSHIFT: class_o = CLS_SHIFT;
            SC_CTRL:              class_o = CLS_CTRL;
            default:              class_o = CLS_OTHER;
        endcase
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: pops bytes from the receiver FIFO at most one per
// three cycles, tracks break/extended prefixes, modifier state and the held
// key, and emits one-cycle press/repeat/release pulses.
module ps2_kbd_ctrl
    import ps2_kbd_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata_n,
    input  logic             clr_ovf,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_press,
    output logic             key_repeat,
    output logic             key_release,
    output logic             key_down,
    output logic             shift_held,
    output logic             ctrl_held,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_flag
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic [7:0]       byte_q, byte_d;
    logic             brk_pend_q, brk_pend_d;
    logic             ext_pend_q, ext_pend_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             key_ext_q, key_ext_d;
    logic             key_press_q, key_press_d;
    logic             key_repeat_q, key_repeat_d;
    logic             key_release_q, key_release_d;
    logic             key_down_q, key_down_d;
    logic             shift_q, shift_d;
    logic             ctrl_q, ctrl_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             ovf_q, ovf_d;
    code_class_e      byte_class_s;

    ps2_code_class u_code_class (
        .code_i  (byte_q),
        .class_o (byte_class_s)
    );

    // Pop sequencer: capture on IDLE->ACK, pop strobe low for the ACK cycle only.
    always_comb begin
        state_d      = state_q;
        nextdata_n_d = 1'b1;
        byte_d       = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (kbd_ready) begin
                    state_d      = ST_ACK;
                    byte_d       = kbd_data;
                    nextdata_n_d = 1'b0;
                end else begin
                    state_d      = ST_IDLE;
                    nextdata_n_d = 1'b1;
                end
            end
            ST_ACK:  state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte decoder: evaluated on the ACK->GAP edge so pulses appear in GAP.
    // Modifier bytes only touch modifier state; key_code/key_ext describe the
    // last ordinary-key event so a held key keeps repeating while ctrl/shift
    // are pressed or released.
    always_comb begin
        brk_pend_d    = brk_pend_q;
        ext_pend_d    = ext_pend_q;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        key_down_d    = key_down_q;
        shift_d       = shift_q;
        ctrl_d        = ctrl_q;
        press_cnt_d   = press_cnt_q;
        key_press_d   = 1'b0;
        key_repeat_d  = 1'b0;
        key_release_d = 1'b0;
        if (state_q == ST_ACK) begin
            case (byte_class_s)
                CLS_BRK: brk_pend_d = 1'b1;
                CLS_EXT: ext_pend_d = 1'b1;
                default: begin
                    brk_pend_d = 1'b0;
                    ext_pend_d = 1'b0;
                    if (is_fake_shift(ext_pend_q, byte_q)) begin
                        brk_pend_d = 1'b0;
                    end else if (byte_class_s == CLS_SHIFT) begin
                        shift_d = ~brk_pend_q;
                    end else if (byte_class_s == CLS_CTRL) begin
                        ctrl_d = ~brk_pend_q;
                    end else if (brk_pend_q) begin
                        key_code_d    = byte_q;
                        key_ext_d     = ext_pend_q;
                        key_release_d = 1'b1;
                        if (byte_q == key_code_q) begin
                            key_down_d = 1'b0;
                        end else begin
                            key_down_d = key_down_q;
                        end
                    end else if (key_down_q && (byte_q == key_code_q) && (ext_pend_q == key_ext_q)) begin
                        key_repeat_d = 1'b1;
                    end else begin
                        key_code_d  = byte_q;
                        key_ext_d   = ext_pend_q;
                        key_down_d  = 1'b1;
                        key_press_d = 1'b1;
                        press_cnt_d = press_cnt_q + CNT_ONE;
                    end
                end
            endcase
        end else begin
            key_press_d = 1'b0;
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_comb begin
        if (kbd_overflow) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State register with synchronous reset that overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            nextdata_n_q  <= 1'b1;
            byte_q        <= 8'h00;
            brk_pend_q    <= 1'b0;
            ext_pend_q    <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_press_q   <= 1'b0;
            key_repeat_q  <= 1'b0;
            key_release_q <= 1'b0;
            key_down_q    <= 1'b0;
            shift_q       <= 1'b0;
            ctrl_q        <= 1'b0;
            press_cnt_q   <= {CNT_W{1'b0}};
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            nextdata_n_q  <= nextdata_n_d;
            byte_q        <= byte_d;
            brk_pend_q    <= brk_pend_d;
            ext_pend_q    <= ext_pend_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            key_press_q   <= key_press_d;
            key_repeat_q  <= key_repeat_d;
            key_release_q <= key_release_d;
            key_down_q    <= key_down_d;
            shift_q       <= shift_d;
            ctrl_q        <= ctrl_d;
            press_cnt_q   <= press_cnt_d;
            ovf_q         <= ovf_d;
        end
    end

    assign kbd_nextdata_n = nextdata_n_q;
    assign key_code       = key_code_q;
    assign key_ext        = key_ext_q;
    assign key_press      = key_press_q;
    assign key_repeat     = key_repeat_q;
    assign key_release    = key_release_q;
    assign key_down       = key_down_q;
    assign shift_held     = shift_q;
    assign ctrl_held      = ctrl_q;
    assign press_cnt      = press_cnt_q;
    assign ovf_flag       = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: a byte-stream reference model pushes the
// expected output state per byte; a monitor pops it in the GAP cycle.
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_ready = 1'b0;
    logic       kbd_overflow = 1'b0;
    logic       kbd_nextdata_n;
    logic       clr_ovf = 1'b0;
    logic [7:0] key_code;
    logic       key_ext, key_press, key_repeat, key_release, key_down;
    logic       shift_held, ctrl_held, ovf_flag;
    logic [7:0] press_cnt;

    ps2_kbd_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n),
        .clr_ovf(clr_ovf), .key_code(key_code), .key_ext(key_ext),
        .key_press(key_press), .key_repeat(key_repeat), .key_release(key_release),
        .key_down(key_down), .shift_held(shift_held), .ctrl_held(ctrl_held),
        .press_cnt(press_cnt), .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model state: what the keyboard has said so far.
    logic       m_brk, m_ext, m_ext_out, m_down, m_shift, m_ctrl;
    logic [7:0] m_code, m_cnt;
    logic [22:0] exp_q[$];

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_ext_out = 0; m_down = 0;
        m_shift = 0; m_ctrl = 0; m_code = 8'h00; m_cnt = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic p, r, l, brk, ext;
        p = 0; r = 0; l = 0;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            brk = m_brk; ext = m_ext; m_brk = 0; m_ext = 0;
            if (ext && b == 8'h12) begin
                p = 0;
            end else if (b == 8'h12 || b == 8'h59) m_shift = !brk;
            else if (b == 8'h14) m_ctrl = !brk;
            else if (brk) begin
                l = 1;
                if (b == m_code) m_down = 0;
                m_code = b; m_ext_out = ext;
            end else if (m_down && b == m_code && ext == m_ext_out) r = 1;
            else begin
                m_code = b; m_ext_out = ext; m_down = 1; p = 1; m_cnt = m_cnt + 8'd1;
            end
        end
        exp_q.push_back({m_code, m_ext_out, p, r, l, m_down, m_shift, m_ctrl, m_cnt});
    endtask

    function automatic logic [22:0] dut_vec();
        return {key_code, key_ext, key_press, key_repeat, key_release,
                key_down, shift_held, ctrl_held, press_cnt};
    endfunction

    // Monitor: the negedge after a pop cycle is the GAP cycle of that byte.
    logic check_en = 1'b0;
    logic nd_prev  = 1'b1;
    always @(negedge clk) begin
        if (check_en) begin
            if (nd_prev == 1'b0) begin
                if (exp_q.size() == 0) chk("unexpected_byte", 64'd1, 64'd0);
                else chk("byte_event", {41'd0, dut_vec()}, {41'd0, exp_q.pop_front()});
            end else if (key_press | key_repeat | key_release) begin
                chk("stray_pulse", {61'd0, key_press, key_repeat, key_release}, 64'd0);
            end
        end
        nd_prev = kbd_nextdata_n;
    end

    // Present one byte at the FIFO head until it is popped.
    task automatic send_byte(input logic [7:0] b);
        int n;
        model_byte(b);
        @(negedge clk);
        kbd_data = b; kbd_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (kbd_nextdata_n !== 1'b0 && n < 50);
        if (n >= 50) begin
            chk("pop_timeout", 64'd1, 64'd0);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        kbd_ready = 1'b0;
        kbd_data  = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    logic [7:0] pool[11];

    initial begin
        pool = '{8'h12, 8'h59, 8'h14, 8'hF0, 8'hF0, 8'hE0, 8'h1C, 8'h1B, 8'h75, 8'h23, 8'h1C};
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {41'd0, dut_vec()}, 64'd0);
        chk("reset_nextdata_n", {63'd0, kbd_nextdata_n}, 64'd1);
        chk("reset_ovf", {63'd0, ovf_flag}, 64'd0);
        rst = 1'b0;
        check_en = 1'b1;

        // IDLE waits indefinitely with no data.
        repeat (10) @(negedge clk);
        chk("idle_no_pop", {63'd0, kbd_nextdata_n}, 64'd1);

        send_seq('{8'h1C, 8'hF0, 8'h1C});
        send_seq('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12});
        send_seq('{8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B});
        send_seq('{8'hE0, 8'h14, 8'hE0, 8'hF0, 8'h14});
        send_seq('{8'hE0, 8'h12, 8'hE0, 8'hF0, 8'h12});
        send_seq('{8'hE0, 8'h75, 8'hE0, 8'h75, 8'h75, 8'hF0, 8'h75});
        drain();

        // Counter wrap: alternate two codes so every make is a fresh press.
        for (int i = 0; i < 256; i++) send_byte((i % 2 == 0) ? 8'h2A : 8'h2B);
        drain();
        chk("press_cnt_wrap", {56'd0, press_cnt}, {56'd0, m_cnt});

        // Overflow: set wins over clear, then sticky, then clear.
        @(negedge clk);
        kbd_overflow = 1'b1; clr_ovf = 1'b1;
        @(negedge clk);
        kbd_overflow = 1'b0; clr_ovf = 1'b0;
        chk("ovf_set_wins", {63'd0, ovf_flag}, 64'd1);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", {63'd0, ovf_flag}, 64'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_clear", {63'd0, ovf_flag}, 64'd0);

        // Random byte stream.
        for (int i = 0; i < 300; i++) send_byte(pool[$urandom_range(0, 10)]);
        drain();

        // Reset while in ACK aborts the pop and produces no event.
        send_seq('{8'h12, 8'h14, 8'h44});
        drain();
        kbd_overflow = 1'b1;
        @(negedge clk);
        kbd_overflow = 1'b0;
        kbd_data = 8'h3C; kbd_ready = 1'b1;
        @(negedge clk);
        chk("ack_before_reset", {63'd0, kbd_nextdata_n}, 64'd0);
        check_en = 1'b0;
        rst = 1'b1; kbd_ready = 1'b0;
        @(negedge clk);
        chk("reset_in_ack_nextdata_n", {63'd0, kbd_nextdata_n}, 64'd1);
        chk("reset_in_ack_outputs", {41'd0, dut_vec()}, 64'd0);
        chk("reset_in_ack_ovf", {63'd0, ovf_flag}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset_no_pulse", {61'd0, key_press, key_repeat, key_release}, 64'd0);
        model_reset();
        check_en = 1'b1;
        send_seq('{8'h1C, 8'h1C});
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of the press counter.
REQ-002 clk  input  1  single system clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 kbd_data  input  8  head byte of the PS/2 receiver FIFO.
REQ-005 kbd_ready  input  1  receiver FIFO non-empty; kbd_data valid.
REQ-006 kbd_overflow  input  1  receiver FIFO overflow indication.
REQ-007 kbd_nextdata_n  output  1  active-low pop; low for one cycle advances the receiver FIFO.
REQ-008 clr_ovf  input  1  clears ovf_flag.
REQ-009 key_code  output  8  scan code of the last event (make, repeat or release).
REQ-010 key_ext  output  1  last event was E0-prefixed.
REQ-011 key_press  output  1  one-cycle pulse: new non-modifier key pressed.
REQ-012 key_repeat  output  1  one-cycle pulse: typematic repeat of the held key.
REQ-013 key_release  output  1  one-cycle pulse: non-modifier key released.
REQ-014 key_down  output  1  a non-modifier key is currently held.
REQ-015 shift_held, ctrl_held  output  1 each  modifier state.
REQ-016 press_cnt  output  CNT_W  count of key_press events.
REQ-017 ovf_flag  output  1  sticky receiver-overflow flag.

Function
REQ-018 FSM states IDLE, ACK, GAP; IDLE->ACK when kbd_ready=1 (kbd_data captured into byte_r on that edge); ACK->GAP unconditionally; GAP->IDLE unconditionally.
REQ-019 kbd_nextdata_n shall be registered, 0 exactly during ACK, 1 in all other states; max throughput one byte per 3 cycles.
REQ-020 Decode of byte_r shall occur at the end of ACK; event pulses shall be high during GAP only, i.e. 2 cycles after the capture edge.
REQ-021 Byte F0: set brk_pend; no pulse; no output change.
REQ-022 Byte E0: set ext_pend; no pulse; no output change.
REQ-023 Any other byte consumes and clears brk_pend and ext_pend; key_ext takes ext_pend.
REQ-024 E0 followed by 12 (with or without F0) is discarded entirely: no flag, counter or output change.
REQ-025 Make of 12 or 59 sets shift_held; make of 14 (plain or E0) sets ctrl_held; modifier makes emit no pulse, no count.
REQ-026 Break of 12/59 clears shift_held; break of 14 clears ctrl_held; no pulse.
REQ-027 Make of non-modifier code equal to key_code while key_down=1 with matching key_ext: key_repeat pulse only; press_cnt unchanged.
REQ-028 Otherwise non-modifier make: key_code<=byte, key_down<=1, key_press pulse, press_cnt+1, wrapping from all-ones to 0.
REQ-029 Non-modifier break: key_code<=byte, key_release pulse; key_down<=0 only if byte equals held key_code, else key_down unchanged.
REQ-030 ovf_flag set on any cycle kbd_overflow=1; cleared by clr_ovf; simultaneous set and clear: set wins.
REQ-031 kbd_ready dropping during ACK/GAP shall not alter sequencing; IDLE waits indefinitely.

Reset
REQ-032 On rst=1 at a clock edge: state IDLE, kbd_nextdata_n=1, byte_r, key_code, press_cnt=0, all flags, pending bits and pulses 0; rst overrides every other input.
REQ-033 Reset during ACK shall abort the pop (nextdata_n=1 next cycle); no event is generated for the captured byte.

Structure
REQ-034 A shared package shall hold the FSM state enum and scan-code constants F0, E0, LSHIFT 12, RSHIFT 59, CTRL 14.
REQ-035 One combinational sub-module ps2_code_class shall classify byte_r into prefix-break, prefix-ext, shift, ctrl, other.

Verification
REQ-036 Bytes 1C,F0,1C -> key_press with key_code=1C, press_cnt=1, then key_release with key_code=1C, key_down=0.
REQ-037 Bytes 12,1C,F0,1C,F0,12 -> shift_held=1 across the 1C press/release, one key_press, shift_held=0 at end.
REQ-038 Bytes 1B,1B,1B,F0,1B -> one key_press, two key_repeat, one key_release; press_cnt=1.
REQ-039 Bytes E0,14,E0,F0,14 -> ctrl_held 1 then 0; E0,12 -> no output change; E0,75 -> key_press, key_ext=1.
REQ-040 press_cnt preset by 255 presses then one more -> 0; kbd_overflow pulse with clr_ovf same cycle -> ovf_flag=1.
REQ-041 rst asserted in ACK -> kbd_nextdata_n=1 next cycle, all outputs 0, no pulse.
